pixel_replication_2x: RTL and testbench
=======================================

PIXEL_REPLICATION_2X -- requirements
Module: pixel_replication_2x

Interface
REQ-001 Parameter IMG_W, default 160, input image width in pixels; legal range 2..1024.
REQ-002 Parameter IMG_H, default 120, input image height in rows; legal range 1..1024.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-006 pixel_in  input  8  input pixel, raster order.
REQ-007 in_valid  input  1  pixel_in is valid.
REQ-008 in_ready  output  1  block accepts pixel_in this cycle.
REQ-009 pixel_out  output  8  output pixel, raster order, 2*IMG_W x 2*IMG_H.
REQ-010 out_valid  output  1  pixel_out is valid.
REQ-011 out_ready  input  1  sink accepts pixel_out this cycle.
REQ-012 out_eol  output  1  qualifies pixel_out as the last pixel of an output row.
REQ-013 out_eof  output  1  qualifies pixel_out as the last pixel of the frame.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the frame's last output transfer.

Function
REQ-016 An input transfer occurs on an edge where in_valid=1 and in_ready=1; an output transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-017 The FSM SHALL have the states IDLE, LOAD, EMIT0, EMIT1 and DONE.
REQ-018 IDLE: start=1 moves to LOAD with row=0 and col=0; start is ignored in all other states.
REQ-019 LOAD: in_ready=1. Each input transfer writes buf[col] and increments col; the transfer at col=IMG_W-1 moves to EMIT0 with col=0.
REQ-020 in_ready SHALL be 0 outside LOAD.
REQ-021 EMIT0 and EMIT1 each produce 2*IMG_W output pixels in order buf[0],buf[0],buf[1],buf[1],...,buf[IMG_W-1],buf[IMG_W-1], so each row is emitted twice.
REQ-022 After the 2*IMG_W-th transfer, EMIT0 moves to EMIT1. EMIT1 moves to DONE if row=IMG_H-1; otherwise it moves to LOAD with row+1.
REQ-023 pixel_out, out_valid, out_eol and out_eof are registered. out_valid first asserts on the 2nd rising edge after the edge that accepts the row's last input pixel (one-cycle buffer read).
REQ-024 While out_valid=1 and out_ready=0, pixel_out, out_eol and out_eof SHALL hold stable.
REQ-025 Back-to-back output transfers SHALL sustain 1 pixel per cycle within EMIT0/EMIT1, including across the EMIT0->EMIT1 boundary.
REQ-026 out_eol=1 on output index 2*IMG_W-1 of each emitted row. out_eof=1 only on the last pixel of EMIT1 when row=IMG_H-1.
REQ-027 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE; done=0 in all other cycles.
REQ-028 Line buffer depth is IMG_W x 8 bits. Counters are sized $clog2(2*IMG_W) and $clog2(IMG_H) and never wrap past their terminal values.
REQ-029 in_valid=0 in LOAD and out_ready=0 in EMIT0/EMIT1 stall the FSM indefinitely without losing or duplicating data.

Reset
REQ-030 On reset_n=0, the FSM goes to IDLE immediately, including mid-frame. All counters clear, and in_ready, out_valid, out_eol, out_eof, busy, done and pixel_out go to 0.
REQ-031 The line buffer contents need not be cleared. A frame aborted by reset produces no further output and no done pulse.

Configuration
REQ-032 Macro PIXEL_REPLICATION_INTERP_H_EN.
- Defined: odd output index 2k+1 = (buf[k]+buf[k+1]+1)>>1, computed in 9 bits, for k<IMG_W-1; for k=IMG_W-1 it is buf[IMG_W-1]. Even indices are unchanged.
- Undefined: pure replication as in REQ-021; no adder is present.

Verification (IMG_W=4, IMG_H=2)
REQ-033 Reset, start, input row 10,20,30,40 and row 50,60,70,80, out_ready=1 -> output rows 10,10,20,20,30,30,40,40 ×2 then 50,50,60,60,70,70,80,80 ×2; 32 transfers, done pulses once.
REQ-034 Same stimulus with out_ready toggling 1,0,0,1,... -> identical 32-pixel sequence; pixel_out stable during every stall.
REQ-035 out_eol on transfers 8,16,24,32; out_eof only on transfer 32; in_ready=0 throughout EMIT0/EMIT1.
REQ-036 reset_n pulsed low after 3 output transfers -> all outputs 0 next cycle, no done; a new start yields a full correct frame.
REQ-037 With PIXEL_REPLICATION_INTERP_H_EN, row 10,20,30,255 -> 10,15,20,25,30,143,255,255 emitted twice.
REQ-038 start asserted during LOAD/EMIT -> ignored; the frame completes unchanged with a single done pulse.

Source files
------------

// File: rtl/pixel_replication_2x.sv
// pixel_replication_2x: 2x nearest-neighbour upscaler. Each input row is
// stored in a line buffer and emitted twice with every pixel doubled.
// Build option: define PIXEL_REPLICATION_INTERP_H_EN to replace every odd
// output pixel with the rounded mean of its two horizontal neighbours.
// Ports:
//   clk, reset_n                - clock, async active-low reset
//   start                       - begin a frame (sampled in IDLE only)
//   pixel_in/in_valid/in_ready  - input pixel stream, raster order
//   pixel_out/out_valid/out_ready - output pixel stream, raster order
//   out_eol, out_eof            - last pixel of output row / of frame
//   busy, done                  - not idle / one-cycle end-of-frame pulse
module pixel_replication_2x #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] pixel_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] pixel_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_eol,
    output logic       out_eof,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(2 * IMG_W);
    localparam int KW = CW - 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] LAST_L = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_E = CW'(2 * IMG_W - 1);
    localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT0,
        S_EMIT1,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          iss_done_q, iss_done_d;

    // Stage 1: registered line-buffer read with its row/frame markers.
    logic          s1_valid_q, s1_valid_d;
    logic [7:0]    s1_pix_q, s1_pix_d;
    logic          s1_eol_q, s1_eol_d;
    logic          s1_eof_q, s1_eof_d;

    // Stage 2: output registers.
    logic          ov_q, ov_d;
    logic [7:0]    pix_q, pix_d;
    logic          eol_q, eol_d;
    logic          eof_q, eof_d;

    logic [7:0]    line_q [IMG_W];

    logic          adv;
    logic          issue;
    logic [KW-1:0] rd_k;
    logic [7:0]    rd_pix;
`ifdef PIXEL_REPLICATION_INTERP_H_EN
    localparam logic [KW-1:0] LAST_K = KW'(IMG_W - 1);
    logic [KW-1:0] rd_kn;
    logic [8:0]    sum;
`endif

    // Line buffer: no reset, contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid)
            line_q[col_q[KW-1:0]] <= pixel_in;
    end

    always_comb begin
        // Whole pipeline moves when the output register is free or draining.
        adv   = !ov_q || out_ready;
        issue = adv && ((state_q == S_EMIT0) ||
                        (state_q == S_EMIT1 && !iss_done_q));
        rd_k  = col_q[CW-1:1];
`ifdef PIXEL_REPLICATION_INTERP_H_EN
        // Clamping k+1 at the right edge makes the mean equal buf[k].
        rd_kn  = (rd_k == LAST_K) ? rd_k : rd_k + 1'b1;
        sum    = {1'b0, line_q[rd_k]} + {1'b0, line_q[rd_kn]} + 9'd1;
        rd_pix = col_q[0] ? sum[8:1] : line_q[rd_k];
`else
        rd_pix = line_q[rd_k];
`endif
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        iss_done_d = iss_done_q;
        s1_valid_d = s1_valid_q;
        s1_pix_d   = s1_pix_q;
        s1_eol_d   = s1_eol_q;
        s1_eof_d   = s1_eof_q;
        ov_d       = ov_q;
        pix_d      = pix_q;
        eol_d      = eol_q;
        eof_d      = eof_q;

        if (adv) begin
            ov_d       = s1_valid_q;
            pix_d      = s1_pix_q;
            eol_d      = s1_eol_q;
            eof_d      = s1_eof_q;
            s1_valid_d = issue;
            if (issue) begin
                s1_pix_d = rd_pix;
                s1_eol_d = (col_q == LAST_E);
                s1_eof_d = (state_q == S_EMIT1) && (row_q == LAST_R) &&
                           (col_q == LAST_E);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (col_q == LAST_L) begin
                        state_d = S_EMIT0;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            // EMIT0 hands over to EMIT1 as soon as its last read issues,
            // so the two copies of the row stream without a bubble.
            S_EMIT0: begin
                if (issue) begin
                    if (col_q == LAST_E) begin
                        state_d = S_EMIT1;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            // EMIT1 stays until its last pixel has actually left, so the
            // next row load and the done pulse follow the final transfer.
            S_EMIT1: begin
                if (issue) begin
                    if (col_q == LAST_E)
                        iss_done_d = 1'b1;
                    else
                        col_d = col_q + 1'b1;
                end
                if (iss_done_q && !s1_valid_q && ov_q && out_ready) begin
                    iss_done_d = 1'b0;
                    col_d      = '0;
                    if (row_q == LAST_R) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        row_d   = row_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            iss_done_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_eol_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            ov_q       <= 1'b0;
            pix_q      <= '0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            iss_done_q <= iss_done_d;
            s1_valid_q <= s1_valid_d;
            s1_pix_q   <= s1_pix_d;
            s1_eol_q   <= s1_eol_d;
            s1_eof_q   <= s1_eof_d;
            ov_q       <= ov_d;
            pix_q      <= pix_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = ov_q;
    assign pixel_out = pix_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;

endmodule

// File: tb/tb_pixel_replication_2x.sv
// tb_pixel_replication_2x: directed bench for the 2x upscaler, 4x2 image.
// Covers reset, full frames with/without backpressure, start abuse, abort.
module tb_pixel_replication_2x;

    localparam int W = 4;
    localparam int H = 2;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       start     = 1'b0;
    logic [7:0] pixel_in  = 8'd0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [7:0] pixel_out;
    logic       out_valid;
    logic       out_eol;
    logic       out_eof;
    logic       busy;
    logic       done;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;
    int d0;

    logic [7:0] rows [H][W];

    pixel_replication_2x #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pixel_in  (pixel_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel_out (pixel_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int r, input int i);
        int k;
`ifdef PIXEL_REPLICATION_INTERP_H_EN
        logic [8:0] s;
`endif
        k = i / 2;
`ifdef PIXEL_REPLICATION_INTERP_H_EN
        if (i % 2 == 1 && k < W - 1) begin
            s = {1'b0, rows[r][k]} + {1'b0, rows[r][k+1]} + 9'd1;
            return s[8:1];
        end
`endif
        return rows[r][k];
    endfunction

    // mode 0: out_ready always 1; mode 1: out_ready 1,0,0 repeating.
    task automatic run_frame(input int mode, input bit hold_start,
                             input int abort_at);
        int n, cyc, t, w, idx, half;
        bit seen;
        n   = 0;
        cyc = 0;
        start = 1'b1;
        @(negedge clk);
        start = hold_start;
        chk("busy_load", busy, 1);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                pixel_in = rows[r][c];
                in_valid = 1'b1;
                t = 0;
                while (in_ready !== 1'b1 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 100) begin
                    chk("in_ready_timeout", t, 0);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            w    = 0;
            seen = 1'b0;
            t    = 0;
            while (n < (r + 1) * 4 * W && t < 200) begin
                out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
                if (!seen && out_valid === 1'b1) begin
                    seen = 1'b1;
                    chk("latency", w, 2);
                end
                if (!seen) w++;
                if (out_valid === 1'b1) begin
                    idx  = n % (2 * W);
                    half = (n / (2 * W)) % 2;
                    chk("pix", pixel_out, exp_pix(r, idx));
                    chk("eol", out_eol, idx == 2 * W - 1);
                    chk("eof", out_eof,
                        (r == H - 1) && (half == 1) && (idx == 2 * W - 1));
                    chk("in_ready_emit", in_ready, 0);
                    if (out_ready) n++;
                end
                @(negedge clk);
                cyc++;
                t++;
                if (abort_at > 0 && n == abort_at) return;
            end
            if (t >= 200) begin
                chk("out_timeout", t, 0);
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("eof_cleared", out_valid, 0);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #3 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_eol", out_eol, 0);
        chk("rst_eof", out_eof, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        rows[0] = '{8'd10, 8'd20, 8'd30, 8'd40};
        rows[1] = '{8'd50, 8'd60, 8'd70, 8'd80};

        d0 = done_cnt;
        run_frame(0, 1'b0, 0);
        chk("done_once_ready", done_cnt - d0, 1);

        d0 = done_cnt;
        run_frame(1, 1'b0, 0);
        chk("done_once_stall", done_cnt - d0, 1);

        d0 = done_cnt;
        run_frame(0, 1'b1, 0);
        repeat (3) @(negedge clk);
        chk("start_ignored_busy", busy, 0);
        chk("done_once_start", done_cnt - d0, 1);

        rows[0] = '{8'd10, 8'd20, 8'd30, 8'd255};
        rows[1] = '{8'd0, 8'd255, 8'd1, 8'd128};
        d0 = done_cnt;
        run_frame(1, 1'b0, 0);
        chk("done_once_edge", done_cnt - d0, 1);

        rows[0] = '{8'd10, 8'd20, 8'd30, 8'd40};
        rows[1] = '{8'd50, 8'd60, 8'd70, 8'd80};
        d0 = done_cnt;
        run_frame(0, 1'b0, 3);
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_pixel_out", pixel_out, 0);
        chk("abort_eol", out_eol, 0);
        chk("abort_eof", out_eof, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_quiet_valid", out_valid, 0);
        chk("abort_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        run_frame(1, 1'b0, 0);
        chk("done_once_after_abort", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
